// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of one shared memory port.
// Optional macro MEM_ARBITER_RR_EN switches conflict resolution from fixed dmem priority to round-robin.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE, IMEM_BUSY, DMEM_BUSY} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  rmask_q, rmask_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;

  logic imem_req, dmem_req, grant_dmem;

  assign imem_req = |imem_rmask;
  assign dmem_req = (|dmem_rmask) | (|dmem_wmask);

`ifdef MEM_ARBITER_RR_EN
  // last_grant_q: 1 = dmem won the most recent conflict; only conflicts update it
  logic last_grant_q, last_grant_d;

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b0;
    else     last_grant_q <= last_grant_d;
  end

  always_comb begin
    grant_dmem   = dmem_req & (~imem_req | ~last_grant_q);
    last_grant_d = last_grant_q;
    if (state_q == IDLE && imem_req && dmem_req)
      last_grant_d = grant_dmem;
  end
`else
  assign grant_dmem = dmem_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
    end
  end

  // Request registers are cleared on return to IDLE so mem_* read as zero there
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_dmem) begin
          state_d = DMEM_BUSY;
          addr_d  = dmem_addr & 32'hFFFF_FFFC;
          rmask_d = dmem_rmask;
          wmask_d = dmem_wmask;
          wdata_d = dmem_wdata;
        end else if (imem_req) begin
          state_d = IMEM_BUSY;
          addr_d  = imem_addr & 32'hFFFF_FFFC;
          rmask_d = imem_rmask;
          wmask_d = 4'b0000;
          wdata_d = 32'h0;
        end
      end
      IMEM_BUSY, DMEM_BUSY: begin
        if (mem_resp) begin
          state_d = IDLE;
          addr_d  = 32'h0;
          rmask_d = 4'b0000;
          wmask_d = 4'b0000;
          wdata_d = 32'h0;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = 32'h0;
        rmask_d = 4'b0000;
        wmask_d = 4'b0000;
        wdata_d = 32'h0;
      end
    endcase
  end

  always_comb begin
    mem_addr   = addr_q;
    mem_rmask  = rmask_q;
    mem_wmask  = wmask_q;
    mem_wdata  = wdata_q;
    imem_resp  = (state_q == IMEM_BUSY) && mem_resp && !rst;
    dmem_resp  = (state_q == DMEM_BUSY) && mem_resp && !rst;
    imem_rdata = imem_resp ? mem_rdata : 32'h0;
    dmem_rdata = dmem_resp ? mem_rdata : 32'h0;
  end

  // A data request may read or write, never both
  assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> !((|dmem_rmask) && (|dmem_wmask)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the memory (0 none, 1 imem, 2 dmem) and what it asked for
  int          m_owner;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_rmask, m_wmask;
  bit          m_last_dmem;
  bit          m_done_i, m_done_d, m_granted;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clearModel();
    m_owner = 0;
    m_addr  = 32'h0;
    m_rmask = 4'h0;
    m_wmask = 4'h0;
    m_wdata = 32'h0;
  endtask

  // Applies the arbitration rules to the inputs present at this clock edge
  task automatic modelUpdate();
    bit ireq, dreq;
    int win;
    ireq = |imem_rmask;
    dreq = (|dmem_rmask) || (|dmem_wmask);
    m_done_i = 0;
    m_done_d = 0;
    m_granted = 0;
    if (rst) begin
      clearModel();
      m_last_dmem = 0;
    end else if (m_owner != 0) begin
      if (mem_resp) begin
        if (m_owner == 1) m_done_i = 1;
        else              m_done_d = 1;
        clearModel();
      end
    end else begin
      win = 0;
      if (ireq && dreq) begin
`ifdef MEM_ARBITER_RR_EN
        win = m_last_dmem ? 1 : 2;
        m_last_dmem = (win == 2);
`else
        win = 2;
`endif
      end else if (dreq) win = 2;
      else if (ireq)     win = 1;
      if (win == 1) begin
        m_owner = 1;
        m_addr  = imem_addr & 32'hFFFF_FFFC;
        m_rmask = imem_rmask;
        m_wmask = 4'h0;
        m_wdata = 32'h0;
      end else if (win == 2) begin
        m_owner = 2;
        m_addr  = dmem_addr & 32'hFFFF_FFFC;
        m_rmask = dmem_rmask;
        m_wmask = dmem_wmask;
        m_wdata = dmem_wdata;
      end
      m_granted = (win != 0);
    end
  endtask

  // Inputs are already driven; compare every output against the model mid-cycle
  task automatic applyStimulus();
    bit exp_ir, exp_dr;
    #1;
    exp_ir = (m_owner == 1) && mem_resp && !rst;
    exp_dr = (m_owner == 2) && mem_resp && !rst;
    checkOutput("mem_addr",   mem_addr,         m_addr);
    checkOutput("mem_rmask",  32'(mem_rmask),   32'(m_rmask));
    checkOutput("mem_wmask",  32'(mem_wmask),   32'(m_wmask));
    checkOutput("mem_wdata",  mem_wdata,        m_wdata);
    checkOutput("imem_resp",  32'(imem_resp),   32'(exp_ir));
    checkOutput("dmem_resp",  32'(dmem_resp),   32'(exp_dr));
    checkOutput("imem_rdata", imem_rdata,       exp_ir ? mem_rdata : 32'h0);
    checkOutput("dmem_rdata", dmem_rdata,       exp_dr ? mem_rdata : 32'h0);
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    rst        = 1'b0;
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    mem_resp   = 1'b0;
  endtask

  initial begin
    bit          i_pend, d_pend;
    logic [31:0] i_addr, d_addr, d_wdata, cur_i, cur_d, exp_a;
    logic [3:0]  i_rmask, d_rmask, d_wmask;
    int          lat;
    int          exp_win [3];

    idleInputs();
    rst = 1'b1;
    imem_addr = 32'h0; dmem_addr = 32'h0; dmem_wdata = 32'h0; mem_rdata = 32'h0;
    clearModel();
    m_last_dmem = 0;
    @(negedge clk);

    // Reset
    applyStimulus(); clockEdge();
    rst = 1'b0;
    applyStimulus();
    checkOutput("reset_rmask", 32'(mem_rmask), 32'h0);
    checkOutput("reset_addr", mem_addr, 32'h0);
    clockEdge();

    // Fetch only, unaligned address, response in the third cycle
    imem_addr = 32'h6000_0006; imem_rmask = 4'hF;
    applyStimulus(); clockEdge();
    applyStimulus();
    checkOutput("fetch_addr1", mem_addr, 32'h6000_0004);
    clockEdge();
    applyStimulus(); clockEdge();
    mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
    applyStimulus();
    checkOutput("fetch_addr", mem_addr, 32'h6000_0004);
    checkOutput("fetch_resp", 32'(imem_resp), 32'h1);
    checkOutput("fetch_rdata", imem_rdata, 32'h0000_0013);
    clockEdge();
    idleInputs();
    applyStimulus();
    checkOutput("fetch_idle", 32'(mem_rmask), 32'h0);
    clockEdge();

    // Simultaneous requests: dmem store first, then the waiting fetch
    imem_addr = 32'h2000; imem_rmask = 4'hF;
    dmem_addr = 32'h1000; dmem_wmask = 4'hF; dmem_wdata = 32'hDEAD_BEEF;
    applyStimulus(); clockEdge();
    mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
    applyStimulus();
    checkOutput("conf_wmask", 32'(mem_wmask), 32'hF);
    checkOutput("conf_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("conf_dresp", 32'(dmem_resp), 32'h1);
    checkOutput("conf_iresp", 32'(imem_resp), 32'h0);
    clockEdge();
    dmem_wmask = 4'h0; mem_resp = 1'b0;
    applyStimulus(); clockEdge();
    mem_resp = 1'b1;
    applyStimulus();
    checkOutput("conf_iaddr", mem_addr, 32'h2000);
    checkOutput("conf_iwmask", 32'(mem_wmask), 32'h0);
    checkOutput("conf_iresp2", 32'(imem_resp), 32'h1);
    clockEdge();
    idleInputs();
    applyStimulus(); clockEdge();

    // Stalled memory: request held stable while dmem inputs wander
    dmem_addr = 32'h3004; dmem_rmask = 4'h3;
    applyStimulus(); clockEdge();
    for (int k = 0; k < 10; k++) begin
      dmem_addr  = $urandom;
      dmem_rmask = 4'($urandom_range(1, 15));
      dmem_wdata = $urandom;
      applyStimulus();
      checkOutput("stall_addr", mem_addr, 32'h3004);
      checkOutput("stall_rmask", 32'(mem_rmask), 32'h3);
      clockEdge();
    end
    mem_resp = 1'b1; mem_rdata = 32'hCAFE_0001;
    applyStimulus();
    checkOutput("stall_rdata", dmem_rdata, 32'hCAFE_0001);
    clockEdge();
    idleInputs();
    applyStimulus(); clockEdge();

    // Reset while busy abandons the transaction; the late response is ignored
    dmem_addr = 32'h4000; dmem_wmask = 4'hF; dmem_wdata = 32'h5555_AAAA;
    applyStimulus(); clockEdge();
    rst = 1'b1;
    applyStimulus(); clockEdge();
    rst = 1'b0; dmem_wmask = 4'h0; mem_resp = 1'b1;
    applyStimulus();
    checkOutput("rstbusy_dresp", 32'(dmem_resp), 32'h0);
    checkOutput("rstbusy_wmask", 32'(mem_wmask), 32'h0);
    checkOutput("rstbusy_addr", mem_addr, 32'h0);
    clockEdge();

    // Spurious memory response while idle
    idleInputs();
    mem_resp = 1'b1; mem_rdata = $urandom;
    applyStimulus();
    checkOutput("spur_iresp", 32'(imem_resp), 32'h0);
    checkOutput("spur_dresp", 32'(dmem_resp), 32'h0);
    clockEdge();
    mem_resp = 1'b0;
    applyStimulus();
    checkOutput("spur_idle", 32'(mem_rmask), 32'h0);
    clockEdge();

    // Three back-to-back conflicts from a fresh reset
`ifdef MEM_ARBITER_RR_EN
    exp_win = '{2, 1, 2};
`else
    exp_win = '{2, 2, 2};
`endif
    rst = 1'b1;
    applyStimulus(); clockEdge();
    rst = 1'b0;
    cur_i = 32'h100; cur_d = 32'h200;
    for (int k = 0; k < 3; k++) begin
      imem_addr = cur_i; imem_rmask = 4'hF;
      dmem_addr = cur_d; dmem_rmask = 4'hF; dmem_wmask = 4'h0;
      mem_resp = 1'b0;
      applyStimulus(); clockEdge();
      mem_resp = 1'b1;
      exp_a = (exp_win[k] == 2) ? cur_d : cur_i;
      applyStimulus();
      checkOutput("b2b_grant", mem_addr, exp_a);
      clockEdge();
      if (exp_win[k] == 2) cur_d = cur_d + 32'h10;
      else                 cur_i = cur_i + 32'h10;
    end
    idleInputs();
    applyStimulus(); clockEdge();

    // Random traffic against the model
    i_pend = 0; d_pend = 0; lat = 0;
    i_addr = 32'h0; i_rmask = 4'h0;
    d_addr = 32'h0; d_rmask = 4'h0; d_wmask = 4'h0; d_wdata = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend  = 1;
        i_addr  = $urandom;
        i_rmask = 4'($urandom_range(1, 15));
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend  = 1;
        d_addr  = $urandom;
        d_wdata = $urandom;
        if ($urandom_range(0, 1) == 0) begin
          d_rmask = 4'($urandom_range(1, 15)); d_wmask = 4'h0;
        end else begin
          d_rmask = 4'h0; d_wmask = 4'($urandom_range(1, 15));
        end
      end
      if (m_owner == 2 && $urandom_range(0, 3) == 0) begin
        d_addr = $urandom; d_wdata = $urandom;
      end
      if (m_owner == 1 && $urandom_range(0, 3) == 0) i_addr = $urandom;
      imem_addr  = i_addr;
      imem_rmask = i_pend ? i_rmask : 4'h0;
      dmem_addr  = d_addr;
      dmem_wdata = d_wdata;
      dmem_rmask = d_pend ? d_rmask : 4'h0;
      dmem_wmask = d_pend ? d_wmask : 4'h0;
      mem_rdata  = $urandom;
      if (m_owner != 0) begin
        mem_resp = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        mem_resp = ($urandom_range(0, 9) == 0);
      end
      rst = ($urandom_range(0, 79) == 0);
      applyStimulus(); clockEdge();
      if (m_done_i) i_pend = 0;
      if (m_done_d) d_pend = 0;
      if (m_granted) lat = $urandom_range(0, 12);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: imem_addr  input  32  fetch address; imem_rmask  input  4  fetch read mask, nonzero = request.
REQ-004 SHALL have ports: imem_rdata  output  32  fetch data; imem_resp  output  1  one-cycle fetch completion.
REQ-005 SHALL have ports: dmem_addr  input  32; dmem_rmask  input  4; dmem_wmask  input  4; dmem_wdata  input  32; nonzero rmask or wmask = request.
REQ-006 SHALL have ports: dmem_rdata  output  32; dmem_resp  output  1  one-cycle data completion.
REQ-007 SHALL have ports: mem_addr  output  32; mem_rmask  output  4; mem_wmask  output  4; mem_wdata  output  32  shared memory request.
REQ-008 SHALL have ports: mem_rdata  input  32; mem_resp  input  1  memory completion, valid one cycle.

Function
REQ-009 SHALL implement FSM states IDLE, IMEM_BUSY, DMEM_BUSY.
REQ-010 In IDLE, SHALL sample requests at posedge: dmem only -> DMEM_BUSY; imem only -> IMEM_BUSY; neither -> stay IDLE.
REQ-011 On simultaneous imem and dmem requests in IDLE, SHALL grant dmem (fixed priority, macro off).
REQ-012 On grant, SHALL latch the granted addr, masks and wdata into registers; mem_* SHALL be driven only from these registers.
REQ-013 SHALL force mem_addr[1:0] to 2'b00; masks pass unchanged.
REQ-014 In IMEM_BUSY, SHALL force mem_wmask = 4'b0000 and mem_wdata = 0.
REQ-015 In BUSY states, SHALL hold mem_* stable every cycle until mem_resp = 1.
REQ-016 On mem_resp in IMEM_BUSY, SHALL assert imem_resp and imem_rdata = mem_rdata combinationally that cycle; likewise for dmem in DMEM_BUSY; then SHALL go IDLE.
REQ-017 SHALL return mem_rmask, mem_wmask to 0 in IDLE; minimum request-to-resp latency is 2 cycles (sample edge + memory cycle).
REQ-018 SHALL never assert imem_resp and dmem_resp in the same cycle, and never without a matching mem_resp.
REQ-019 SHALL ignore mem_resp while IDLE (no requester resp, no state change).
REQ-020 SHALL ignore a requester's input changes while another or same transaction is BUSY; the non-granted request waits and is re-sampled in IDLE.
REQ-021 Requesters SHALL deassert or replace their request in the cycle after their resp; arbiter SHALL not filter stale requests.
REQ-022 A dmem request with both rmask and wmask nonzero is illegal; SHALL flag via simulation assertion.
REQ-023 Outputs imem_rdata/dmem_rdata SHALL be 0 when the corresponding resp is 0.

Reset
REQ-024 On rst, SHALL enter IDLE, clear latched request registers and all outputs to 0 at next posedge.
REQ-025 rst during BUSY SHALL abandon the transaction; no resp issued for it; late mem_resp after reset ignored per REQ-019.

Configuration
REQ-026 SHALL support macro MEM_ARBITER_RR_EN: defined -> round-robin on simultaneous requests, using a 1-bit last_grant register (reset = imem, so first conflict grants dmem), loser wins next conflict.
REQ-027 MEM_ARBITER_RR_EN undefined -> fixed dmem priority per REQ-011, no last_grant register.

Verification
REQ-028 Fetch only: imem_addr=0x60000006, rmask=0xF; mem_resp at cycle 3 with rdata=0x00000013 -> mem_addr=0x60000004, imem_resp=1, imem_rdata=0x00000013 that cycle, IDLE next.
REQ-029 Conflict: both request at cycle 0 (dmem sw 0x1000, wdata 0xDEADBEEF) -> dmem served first, mem_wmask=0xF; imem granted in IDLE after dmem_resp.
REQ-030 With MEM_ARBITER_RR_EN: three back-to-back conflicts -> grant order dmem, imem, dmem.
REQ-031 Stall: mem_resp delayed 10 cycles -> mem_* constant for all 10 cycles; dmem input changes mid-wait ignored.
REQ-032 rst asserted in DMEM_BUSY, mem_resp next cycle -> no dmem_resp, state IDLE, all outputs 0.
REQ-033 Spurious mem_resp in IDLE -> both resp stay 0, state unchanged.
